uart_bus_bridge: RTL and testbench
==================================

Name: uart_bus_bridge

Overview:
- Sits directly downstream of the UART byte engine and consumes its received bytes (`received`, `rx_byte`, `recv_error`).
- Parses a fixed binary command protocol into single-word memory-bus reads and writes, used for program loading and debug poke/peek.
- Returns response bytes through the same UART's transmit handshake (`transmit`, `tx_byte`, `is_transmitting`).
- One frame is in flight at a time; there is no pipelining between frames.

Parameters:
- ADDR_W, 32, bus address width; must be a multiple of 8.
- DATA_W, 32, bus data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 100000, maximum idle clk cycles between bytes of one frame before the frame is abandoned; counter is 20 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- uart_received  in  1  one-cycle pulse: rx byte valid
- uart_rx_byte  in  8  received byte
- uart_recv_error  in  1  framing-error pulse from UART
- uart_is_transmitting  in  1  UART TX busy
- uart_transmit  out  1  one-cycle request to send uart_tx_byte
- uart_tx_byte  out  8  byte to send
- bus_req  out  1  bus request, held until bus_ack
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  ADDR_W  word address
- bus_wdata  out  DATA_W  write data
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion
- busy  out  1  high whenever state != S_CMD
- overrun  out  1  sticky; set when a byte arrives in S_BUS/S_RESP; cleared only by rst

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs go to 0 and state to S_CMD. Reset mid-frame or mid-bus-transaction drops bus_req the next cycle; the bus side must tolerate this abandonment.
- Protocol (multi-byte fields MSB first):
  - Write frame: 0x57, ADDR_W/8 address bytes, DATA_W/8 data bytes. Response: 0x4B.
  - Read frame: 0x52, ADDR_W/8 address bytes. Response: DATA_W/8 bytes of read data.
  - Any other command byte: respond 0x45 and return to S_CMD.
- States:
  - S_CMD: on uart_received, latch the command; go to S_ADDR with byte count = ADDR_W/8; an unknown command goes to S_RESP with 0x45.
  - S_ADDR: each byte is shifted into bus_addr from the LSB side. After the last byte: write → S_DATA, read → S_BUS.
  - S_DATA: same shifting into bus_wdata; after the last byte → S_BUS.
  - S_BUS:
    - bus_req = 1 and bus_we is held stable from entry until bus_ack is sampled.
    - On bus_ack, go to S_RESP. For a read, capture bus_rdata into the response shift register in that cycle.
    - No bus timeout: S_BUS waits indefinitely.
  - S_RESP: sends the queued bytes one at a time. Count is 1 for a write ack or error byte, DATA_W/8 for a read. When the last byte's uart_transmit is issued, go to S_CMD.
- TX handshake:
  - uart_transmit may be asserted only when uart_is_transmitting = 0 and uart_transmit was 0 in the previous cycle. It is high for exactly one cycle.
  - uart_tx_byte is driven in that same cycle and held until the next send.
  - This one-cycle guard covers the UART's one-cycle lag in raising is_transmitting.
- Frame timeout:
  - In S_ADDR/S_DATA a counter reloads on every uart_received.
  - If it reaches TIMEOUT_CYCLES, the frame is discarded silently → S_CMD. No response byte and no bus access.
- uart_recv_error in S_CMD/S_ADDR/S_DATA: discard the frame → S_CMD, no response. In S_BUS/S_RESP it is ignored.
- uart_received in S_BUS/S_RESP: the byte is dropped and overrun is set.
- uart_received and timeout expiry in the same cycle: the byte wins; the counter reloads.
- Latency: from bus_ack to the first uart_transmit is 1 cycle when the UART is idle.

Decomposition:
- Package uart_bridge_pkg:
  - Command codes CMD_WRITE = 8'h57, CMD_READ = 8'h52.
  - Response codes RSP_ACK = 8'h4B, RSP_ERR = 8'h45.
  - State enum: S_CMD, S_ADDR, S_DATA, S_BUS, S_RESP.
- One sub-module, uart_tx_pacer: implements the one-cycle transmit pulse, the guard, and the byte hold. Parser FSM, shift registers and timeout counter stay in the top module.

Test Plan:
- Write frame 57 00 00 10 00 DE AD BE EF, bus_ack 3 cycles after bus_req → single bus write, addr 0x00001000, wdata 0xDEADBEEF, bus_we = 1. Then exactly one uart_transmit with byte 0x4B.
- Read frame 52 00 00 10 00, bus_rdata = 0x12345678 → bus read with bus_we = 0. Four uart_transmit pulses, bytes 12,34,56,78. Each pulse follows uart_is_transmitting low with at least 1 cycle between pulses.
- Command 0x33 → no bus_req; one byte 0x45 sent; next valid frame processed normally.
- Write frame stalled after 3 address bytes for TIMEOUT_CYCLES (set to 50) → return to S_CMD, no bus_req, no tx. A fresh read frame then succeeds.
- Byte injected during S_BUS → overrun = 1 and stays 1. Frame result unaffected. rst clears overrun.
- rst asserted while bus_req = 1 → next cycle bus_req = 0, busy = 0, uart_transmit = 0. A subsequent write frame completes normally.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared protocol constants and parser state encoding for the UART-to-bus bridge.
package uart_bridge_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;
endpackage

// File: rtl/uart_bus_bridge_if.sv
// UART byte handshake and single-word memory bus seen by the bridge.
interface uart_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              uart_received;
  logic [7:0]        uart_rx_byte;
  logic              uart_recv_error;
  logic              uart_is_transmitting;
  logic              uart_transmit;
  logic [7:0]        uart_tx_byte;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    input  uart_received, uart_rx_byte, uart_recv_error, uart_is_transmitting,
    output uart_transmit, uart_tx_byte,
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    output uart_received, uart_rx_byte, uart_recv_error, uart_is_transmitting,
    input  uart_transmit, uart_tx_byte,
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/uart_bus_bridge_tx_pacer.sv
// Issues single-cycle UART transmit pulses and holds the last byte sent.
module uart_tx_pacer (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_req,
  input  logic [7:0] send_byte,
  input  logic       is_transmitting,
  output logic       transmit,
  output logic [7:0] tx_byte
);
  logic       tx_prev;
  logic [7:0] tx_hold;

  // The UART raises is_transmitting one cycle late, so the previous pulse also blocks.
  assign transmit = send_req && !is_transmitting && !tx_prev;
  assign tx_byte  = transmit ? send_byte : tx_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_prev <= 1'b0;
      tx_hold <= 8'h00;
    end else begin
      tx_prev <= transmit;
      if (transmit) tx_hold <= send_byte;
    end
  end
endmodule

// File: rtl/uart_bus_bridge.sv
// Parses binary UART command frames into single-word bus reads/writes and returns responses.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  uart_bus_bridge_if.master  bif,
  output logic               busy,
  output logic               overrun
);
  localparam int ABYTES = ADDR_W / 8;
  localparam int DBYTES = DATA_W / 8;

  state_t            state, state_nx;
  logic [7:0]        cnt;
  logic              is_write;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] wdata_sr;
  logic [DATA_W-1:0] resp_sr;
  logic [19:0]       to_cnt;
  logic              fire;
  logic              rx, err, last, timeout, known_cmd;
  logic [7:0]        tx_byte;

  assign rx        = bif.uart_received;
  assign err       = bif.uart_recv_error;
  assign last      = (cnt == 8'd1);
  assign timeout   = (to_cnt == 20'(TIMEOUT_CYCLES));
  assign known_cmd = (bif.uart_rx_byte == CMD_WRITE) || (bif.uart_rx_byte == CMD_READ);

  assign busy          = (state != S_CMD);
  assign bif.bus_req   = (state == S_BUS);
  assign bif.bus_we    = is_write;
  assign bif.bus_addr  = addr_sr;
  assign bif.bus_wdata = wdata_sr;

  always_ff @(posedge clk) begin
    if (rst) state <= S_CMD;
    else     state <= state_nx;
  end

  // A received byte outranks timeout expiry; a framing error outranks both.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_CMD:  if (!err && rx) state_nx = known_cmd ? S_ADDR : S_RESP;
      S_ADDR: begin
        if (err)             state_nx = S_CMD;
        else if (rx && last) state_nx = is_write ? S_DATA : S_BUS;
        else if (!rx && timeout) state_nx = S_CMD;
      end
      S_DATA: begin
        if (err)             state_nx = S_CMD;
        else if (rx && last) state_nx = S_BUS;
        else if (!rx && timeout) state_nx = S_CMD;
      end
      S_BUS:  if (bif.bus_ack) state_nx = S_RESP;
      S_RESP: if (fire && last) state_nx = S_CMD;
      default: state_nx = S_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 8'd0;
      is_write <= 1'b0;
      addr_sr  <= '0;
      wdata_sr <= '0;
      resp_sr  <= '0;
      to_cnt   <= 20'd0;
      overrun  <= 1'b0;
    end else begin
      if ((state == S_ADDR) || (state == S_DATA)) to_cnt <= rx ? 20'd0 : to_cnt + 20'd1;
      else                                        to_cnt <= 20'd0;
      if (rx && ((state == S_BUS) || (state == S_RESP))) overrun <= 1'b1;

      unique case (state)
        S_CMD: if (rx && !err) begin
          is_write <= (bif.uart_rx_byte == CMD_WRITE);
          if (known_cmd) cnt <= 8'(ABYTES);
          else begin
            cnt     <= 8'd1;
            resp_sr <= DATA_W'(RSP_ERR) << (DATA_W - 8);
          end
        end
        S_ADDR: if (rx && !err) begin
          addr_sr <= (addr_sr << 8) | ADDR_W'(bif.uart_rx_byte);
          cnt     <= last ? 8'(DBYTES) : cnt - 8'd1;
        end
        S_DATA: if (rx && !err) begin
          wdata_sr <= (wdata_sr << 8) | DATA_W'(bif.uart_rx_byte);
          cnt      <= cnt - 8'd1;
        end
        S_BUS: if (bif.bus_ack) begin
          if (is_write) begin
            resp_sr <= DATA_W'(RSP_ACK) << (DATA_W - 8);
            cnt     <= 8'd1;
          end else begin
            resp_sr <= bif.bus_rdata;
            cnt     <= 8'(DBYTES);
          end
        end
        S_RESP: if (fire) begin
          resp_sr <= resp_sr << 8;
          cnt     <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  uart_tx_pacer u_pacer (
    .clk             (clk),
    .rst             (rst),
    .send_req        (state == S_RESP),
    .send_byte       (resp_sr[DATA_W-1 -: 8]),
    .is_transmitting (bif.uart_is_transmitting),
    .transmit        (fire),
    .tx_byte         (tx_byte)
  );

  assign bif.uart_transmit = fire;
  assign bif.uart_tx_byte  = tx_byte;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: frames in over UART, bus and TX activity checked against queues.
module tb_uart_bus_bridge;
  localparam int TXLEN = 6;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, overrun;

  uart_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  uart_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(50)) dut (
    .clk     (clk),
    .rst     (rst),
    .bif     (bif.master),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bus_exp_t   exp_bus[$];
  logic [7:0] exp_tx[$];

  logic [31:0] rd_value  = 32'h0;
  int          ack_delay = 3;
  logic        bus_stall = 1'b0;
  logic        tx_pend   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus slave: acks after ack_delay cycles of bus_req unless stalled.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bif.bus_ack = 1'b0;
    bif.bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bif.bus_ack = 1'b0;
      if (bif.bus_req && !rst && !bus_stall) begin
        wait_cnt++;
        if (wait_cnt == ack_delay) begin
          bif.bus_ack = 1'b1;
          bif.bus_rdata = rd_value;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // UART transmitter: raises is_transmitting one cycle late, stays busy TXLEN cycles.
  initial begin
    int busy_cnt;
    logic lag;
    busy_cnt = 0;
    lag = 1'b0;
    bif.uart_is_transmitting = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_pend) begin
        tx_pend = 1'b0;
        lag = 1'b1;
      end else if (lag) begin
        lag = 1'b0;
        bif.uart_is_transmitting = 1'b1;
        busy_cnt = TXLEN;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bif.uart_is_transmitting = 1'b0;
      end
    end
  end

  // Monitors: pop scoreboard on bus request rise and on every transmit pulse.
  initial begin
    logic prev_req, prev_tx, prev_ack;
    bus_exp_t eb;
    logic [7:0] et;
    prev_req = 1'b0; prev_tx = 1'b0; prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bif.bus_req && !prev_req) begin
        if (exp_bus.size() == 0) check("bus_unexpected", 1, 0);
        else begin
          eb = exp_bus.pop_front();
          check("bus_we", bif.bus_we, eb.we);
          check("bus_addr", bif.bus_addr, eb.addr);
          if (eb.we) check("bus_wdata", bif.bus_wdata, eb.wdata);
        end
      end
      if (prev_ack && !bif.uart_is_transmitting) check("ack_to_tx_latency", bif.uart_transmit, 1);
      if (bif.uart_transmit) begin
        tx_pend = 1'b1;
        check("tx_guard", bif.uart_is_transmitting | prev_tx, 0);
        if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
        else begin
          et = exp_tx.pop_front();
          check("tx_byte", bif.uart_tx_byte, et);
        end
      end
      prev_req = bif.bus_req;
      prev_tx  = bif.uart_transmit;
      prev_ack = bif.bus_ack;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=%0d expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bif.uart_received = 1'b1;
    bif.uart_rx_byte = b;
    @(posedge clk); #1;
    bif.uart_received = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data, input logic with_data);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
    if (with_data) for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8]);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk); #2;
      if (!busy && exp_tx.size() == 0 && exp_bus.size() == 0) done = 1'b1;
    end
    check("wait_idle_done", done, 1);
  endtask

  task automatic wait_req();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #2;
      if (bif.bus_req) seen = 1'b1;
    end
    check("wait_bus_req", seen, 1);
  endtask

  initial begin
    bif.uart_received = 1'b0;
    bif.uart_rx_byte = 8'h00;
    bif.uart_recv_error = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_bus_req", bif.bus_req, 0);
    check("rst_transmit", bif.uart_transmit, 0);
    check("rst_tx_byte", bif.uart_tx_byte, 0);
    check("rst_bus_addr", bif.bus_addr, 0);

    // Write frame
    exp_bus.push_back('{we: 1'b1, addr: 32'h0000_1000, wdata: 32'hDEAD_BEEF});
    exp_tx.push_back(8'h4B);
    send_frame(8'h57, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
    wait_idle();
    check("tx_byte_held", bif.uart_tx_byte, 8'h4B);

    // Read frame
    rd_value = 32'h1234_5678;
    exp_bus.push_back('{we: 1'b0, addr: 32'h0000_1000, wdata: 32'h0});
    exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
    send_frame(8'h52, 32'h0000_1000, 32'h0, 1'b0);
    wait_idle();

    // Unknown command, then a normal write
    exp_tx.push_back(8'h45);
    send_byte(8'h33);
    wait_idle();
    exp_bus.push_back('{we: 1'b1, addr: 32'h0000_2004, wdata: 32'hCAFE_0001});
    exp_tx.push_back(8'h4B);
    send_frame(8'h57, 32'h0000_2004, 32'hCAFE_0001, 1'b1);
    wait_idle();

    // Stalled write frame abandoned by timeout
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    repeat (36) @(posedge clk);
    #2 check("timeout_not_yet_busy", busy, 1);
    repeat (20) @(posedge clk);
    #2 check("timeout_expired_busy", busy, 0);
    rd_value = 32'hA5A5_5A5A;
    exp_bus.push_back('{we: 1'b0, addr: 32'h0000_ABCD, wdata: 32'h0});
    exp_tx.push_back(8'hA5); exp_tx.push_back(8'hA5);
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'h5A);
    send_frame(8'h52, 32'h0000_ABCD, 32'h0, 1'b0);
    wait_idle();

    // Byte injected while the bus access is pending
    bus_stall = 1'b1;
    rd_value = 32'h0BAD_F00D;
    exp_bus.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0});
    exp_tx.push_back(8'h0B); exp_tx.push_back(8'hAD);
    exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
    send_frame(8'h52, 32'h0000_0040, 32'h0, 1'b0);
    wait_req();
    send_byte(8'h99);
    check("overrun_set", overrun, 1);
    bus_stall = 1'b0;
    wait_idle();
    check("overrun_sticky", overrun, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("overrun_cleared", overrun, 0);

    // Reset during an outstanding bus request
    bus_stall = 1'b1;
    exp_bus.push_back('{we: 1'b1, addr: 32'h0000_0080, wdata: 32'h1111_2222});
    send_frame(8'h57, 32'h0000_0080, 32'h1111_2222, 1'b1);
    wait_req();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_bus_req", bif.bus_req, 0);
    check("abort_busy", busy, 0);
    check("abort_transmit", bif.uart_transmit, 0);
    rst = 1'b0;
    bus_stall = 1'b0;
    exp_bus.push_back('{we: 1'b1, addr: 32'h0000_0084, wdata: 32'h3333_4444});
    exp_tx.push_back(8'h4B);
    send_frame(8'h57, 32'h0000_0084, 32'h3333_4444, 1'b1);
    wait_idle();

    repeat (10) @(posedge clk);
    check("scoreboard_empty", 64'(exp_tx.size() + exp_bus.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
